sr_flag_arbiter: RTL and testbench

SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

---
 rtl/sr_flag_arbiter_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/sr_flag_arbiter.sv | 123 ++++++++++++
 tb/tb_sr_flag_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types for the SR flag arbiter: FSM state and SR command encodings.
// ERR_CNT_MAX is only used when SR_FLAG_ARBITER_ERR_CNT_EN is defined.
package sr_flag_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    APPLY = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    ILL  = 2'b11
  } sr_cmd_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: highest priority at index ptr, wrapping
// upward; only requests with their mask bit set may win.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] eligible;
  int              pos;

  assign eligible = req & mask;

  // Walk from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    grant = '0;
    pos   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NREQ;
      if (eligible[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serving SR set/clear commands onto a flag bank.
// Define SR_FLAG_ARBITER_ERR_CNT_EN to add the saturating err_cnt output.
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NBITS = 8,
  localparam int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1,
  localparam int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_s,
  input  logic [NREQ-1:0]      req_r,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBITS-1:0]     q,
  output logic                 busy,
  output logic                 err
`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  state_t          state, state_nxt;
  logic [PTRW-1:0] ptr, win_id, win_nxt, arb_ptr, grant_id;
  logic [NREQ-1:0] arb_mask, grant;
  sr_cmd_t         cmd;
  logic [IDXW-1:0] idx;
  logic            load, cmd_legal;

  rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_rr (
    .req  (req_valid),
    .mask (arb_mask),
    .ptr  (arb_ptr),
    .grant(grant)
  );

  assign win_nxt   = (32'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
  assign cmd_legal = (cmd != ILL) && (32'(idx) < NBITS);

  always_comb begin
    grant_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) grant_id = PTRW'(k);
    end
  end

  // In APPLY the next winner is chosen as if the pointer had already advanced,
  // so back-to-back service needs no idle cycle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    err       = 1'b0;
    busy      = (state != IDLE);
    arb_ptr   = ptr;
    arb_mask  = '1;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = GRANT;
          load      = 1'b1;
        end
      end
      GRANT: state_nxt = APPLY;
      APPLY: begin
        req_ready[win_id] = 1'b1;
        err               = !cmd_legal;
        arb_ptr           = win_nxt;
        arb_mask[win_id]  = 1'b0;
        if (|(req_valid & arb_mask)) begin
          state_nxt = GRANT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      win_id <= '0;
      cmd    <= HOLD;
      idx    <= '0;
      q      <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        win_id <= grant_id;
        cmd    <= sr_cmd_t'({req_s[grant_id], req_r[grant_id]});
        idx    <= req_idx[grant_id*IDXW +: IDXW];
      end
      if (state == APPLY) begin
        ptr <= win_nxt;
        if (cmd_legal) begin
          case (cmd)
            SET:     q[idx] <= 1'b1;
            CLR:     q[idx] <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter; a second NBITS=6 instance covers
// out-of-range indices. Exercises err_cnt when SR_FLAG_ARBITER_ERR_CNT_EN is set.
module tb_sr_flag_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NREQ-1:0]  req_valid, req_s, req_r, req_ready;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [7:0]       q;
  logic             busy, err;
  logic [NREQ-1:0]  v6, s6, r6, rdy6;
  logic [NREQ*IDXW-1:0] idx6;
  logic [5:0]       q6;
  logic             busy6, err6;
`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
  logic [7:0]       err_cnt, err_cnt6;
`endif

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       err;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NBITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_s(req_s), .req_r(req_r),
    .req_idx(req_idx), .req_ready(req_ready), .q(q), .busy(busy), .err(err)
`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  sr_flag_arbiter #(.NREQ(NREQ), .NBITS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(v6), .req_s(s6), .req_r(r6),
    .req_idx(idx6), .req_ready(rdy6), .q(q6), .busy(busy6), .err(err6)
`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
    , .err_cnt(err_cnt6)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic s, input logic r, input logic [2:0] ix);
    req_valid[i] = 1'b1;
    req_s[i] = s;
    req_r[i] = r;
    req_idx[i*IDXW +: IDXW] = ix;
  endtask

  task automatic expectResp(input int i, input logic [7:0] eq, input logic ee, input int gap);
    exp_t e;
    e.id = i; e.q = eq; e.err = ee; e.gap = gap;
    sb.push_back(e);
  endtask

  // Retire each requester's valid right after the edge that closes its APPLY.
  task automatic serviceAll();
    int n;
    logic [NREQ-1:0] done;
    n = 0;
    while ((req_valid != 0 || busy) && n < 100) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~done;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL service_timeout: valid=%b busy=%b, required idle", req_valid, busy);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    v6 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic dut6Cmd(input int i, input logic s, input logic r, input logic [2:0] ix,
                         input logic [5:0] eq, input logic ee);
    v6[i] = 1'b1; s6[i] = s; r6[i] = r; idx6[i*IDXW +: IDXW] = ix;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("nb6_ready", 32'(rdy6), 32'(1 << i));
    checkOutput("nb6_err", 32'(err6), 32'(ee));
    @(posedge clk);
    #1;
    v6[i] = 1'b0;
    checkOutput("nb6_q", 32'(q6), 32'(eq));
  endtask

  initial begin : monitor
    exp_t e;
    int   last_cyc;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && req_ready != 0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_ready: got %b, required none", req_ready);
        end else begin
          e = sb.pop_front();
          checkOutput("ready_onehot", 32'(req_ready), 32'(1 << e.id));
          checkOutput("err_pulse", 32'(err), 32'(e.err));
          if (e.gap != 0) checkOutput("ready_gap", 32'(cyc - last_cyc), 32'(e.gap));
          last_cyc = cyc;
          @(posedge clk);
          #1;
          checkOutput("q_after_apply", 32'(q), 32'(e.q));
          checkOutput("err_after_apply", 32'(err), 32'd0);
        end
      end else if (rst_n && err) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL stray_err: err=1 with ready=%b", req_ready);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_valid = '0; req_s = '0; req_r = '0; req_idx = '0;
    v6 = '0; s6 = '0; r6 = '0; idx6 = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_q", 32'(q), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single SET: busy in k+1, ready/q in k+2
    applyStimulus(1, 1'b1, 1'b0, 3'd3);
    expectResp(1, 8'h08, 1'b0, 0);
    @(negedge clk);
    checkOutput("busy_k", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("busy_k1", 32'(busy), 32'd1);
    checkOutput("ready_k1", 32'(req_ready), 32'd0);
    serviceAll();

    // All four requesters at once after reset: order 0,1,2,3, every 2 cycles
    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 1'b0, 3'(i));
    expectResp(0, 8'h01, 1'b0, 0);
    expectResp(1, 8'h03, 1'b0, 2);
    expectResp(2, 8'h07, 1'b0, 2);
    expectResp(3, 8'h0F, 1'b0, 2);
    serviceAll();

    // Illegal s,r=11, HOLD, CLR and rotation from a non-zero pointer
    doReset();
    applyStimulus(2, 1'b1, 1'b0, 3'd5); expectResp(2, 8'h20, 1'b0, 0); serviceAll();
    applyStimulus(2, 1'b1, 1'b1, 3'd5); expectResp(2, 8'h20, 1'b1, 0); serviceAll();
    applyStimulus(3, 1'b0, 1'b0, 3'd5); expectResp(3, 8'h20, 1'b0, 0); serviceAll();
    applyStimulus(1, 1'b0, 1'b1, 3'd5); expectResp(1, 8'h00, 1'b0, 0); serviceAll();
    applyStimulus(0, 1'b1, 1'b0, 3'd1);
    applyStimulus(3, 1'b1, 1'b0, 3'd2);
    expectResp(3, 8'h04, 1'b0, 0);
    expectResp(0, 8'h06, 1'b0, 2);
    serviceAll();

    // Out-of-range indices on the 6-bit bank
    doReset();
    dut6Cmd(0, 1'b1, 1'b0, 3'd1, 6'h02, 1'b0);
    dut6Cmd(0, 1'b0, 1'b1, 3'd7, 6'h02, 1'b1);
    dut6Cmd(0, 1'b1, 1'b0, 3'd6, 6'h02, 1'b1);
    dut6Cmd(0, 1'b1, 1'b0, 3'd5, 6'h22, 1'b0);

    // Reset during APPLY aborts the command
    doReset();
    applyStimulus(3, 1'b1, 1'b0, 3'd7);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("apply_reached", 32'(req_ready), 32'h8);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(req_ready), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_q", 32'(q), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    checkOutput("abort_q_later", 32'(q), 32'd0);
    @(posedge clk);
    #1;

`ifdef SR_FLAG_ARBITER_ERR_CNT_EN
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(0, 1'b1, 1'b1, 3'd0);
      expectResp(0, 8'h00, 1'b1, 0);
      serviceAll();
      if (i == 254 || i == 255 || i == 300) checkOutput("err_cnt", 32'(err_cnt), 32'(i > 255 ? 255 : i));
    end
`endif

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
